// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared definitions for the PS/2 keyboard tone generator:
//   - PS/2 make scan codes for the 13 playable keys and the two octave keys
//   - 13-entry equal-tempered octave-4 frequency table in millihertz
//   - FSM state enum
//   - widths of the note index and the half-period counter
//   - helper that turns a clock rate and a note frequency into a half-period
// ---------------------------------------------------------------------------
package tone_pkg;

    localparam int NOTE_IDX_W = 4;
    localparam int CNT_W      = 20;
    localparam int NUM_NOTES  = 13;

    // Scan codes of the piano row, C4 up to C5
    localparam logic [7:0] SC_C4  = 8'h1C;
    localparam logic [7:0] SC_CS4 = 8'h1D;
    localparam logic [7:0] SC_D4  = 8'h1B;
    localparam logic [7:0] SC_DS4 = 8'h24;
    localparam logic [7:0] SC_E4  = 8'h23;
    localparam logic [7:0] SC_F4  = 8'h2B;
    localparam logic [7:0] SC_FS4 = 8'h2C;
    localparam logic [7:0] SC_G4  = 8'h34;
    localparam logic [7:0] SC_GS4 = 8'h35;
    localparam logic [7:0] SC_A4  = 8'h33;
    localparam logic [7:0] SC_AS4 = 8'h3C;
    localparam logic [7:0] SC_B4  = 8'h3B;
    localparam logic [7:0] SC_C5  = 8'h42;

    // Octave keys (only acted on when octave control is compiled in)
    localparam logic [7:0] SC_OCT_DOWN = 8'h1A;
    localparam logic [7:0] SC_OCT_UP   = 8'h22;

    // Octave-4 note frequencies in mHz, indexed by note_index
    localparam logic [19:0] NOTE_FREQ_MHZ [NUM_NOTES] = '{
        20'd261626, 20'd277183, 20'd293665, 20'd311127,
        20'd329628, 20'd349228, 20'd369994, 20'd391995,
        20'd415305, 20'd440000, 20'd466164, 20'd493883,
        20'd523251
    };

    typedef enum logic {
        IDLE,
        PLAYING
    } tone_state_e;

    // floor(clk_hz * 1000 / (2 * f_mHz)); evaluated on constants only
    function automatic longint half_period(longint clk_hz, longint freq_mhz);
        return (clk_hz * 64'sd1000) / (64'sd2 * freq_mhz);
    endfunction

endpackage

// File: rtl/note_decoder.sv
// ---------------------------------------------------------------------------
// note_decoder
// Purely combinational lookup from a PS/2 make scan code to a semitone
// index. The parent registers the result.
// Ports:
//   key        in   8  scan code of the held key, 0 = none
//   valid      out  1  key is one of the 13 playable codes
//   index      out  4  semitone index 0..12, forced to 0 when not valid
// ---------------------------------------------------------------------------
module note_decoder
    import tone_pkg::*;
(
    input  logic [7:0]            key,
    output logic                  valid,
    output logic [NOTE_IDX_W-1:0] index
);

    // Every code not listed, including 00 and the octave keys, is unmapped
    always_comb begin
        valid = 1'b1;
        index = '0;
        case (key)
            SC_C4:   index = 4'd0;
            SC_CS4:  index = 4'd1;
            SC_D4:   index = 4'd2;
            SC_DS4:  index = 4'd3;
            SC_E4:   index = 4'd4;
            SC_F4:   index = 4'd5;
            SC_FS4:  index = 4'd6;
            SC_G4:   index = 4'd7;
            SC_GS4:  index = 4'd8;
            SC_A4:   index = 4'd9;
            SC_AS4:  index = 4'd10;
            SC_B4:   index = 4'd11;
            SC_C5:   index = 4'd12;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/tone_generator.sv
// ---------------------------------------------------------------------------
// tone_generator
// Square-wave tone generator driven by the scan code of the held PS/2 key.
// The scan code is decoded and registered, a two-state FSM starts/stops the
// tone, and a 20-bit down counter sets the half-period of the note.
// Half-periods are constants derived from CLK_FREQ_HZ at elaboration.
//
// Optional feature: define TONE_GENERATOR_OCTAVE_KEYS_EN to compile in the
// octave register (keys 1A down / 22 up, octaves 3..5, saturating).
//
// Ports:
//   sys_clk     in   1  single clock
//   async_rst   in   1  asynchronous active-high reset
//   key         in   8  scan code of the held key, 0 = none
//   audio_out   out  1  square wave to the speaker
//   note_valid  out  1  registered: key maps to a playable note
//   note_index  out  4  registered semitone index, 0 when note_valid is low
//   playing     out  1  FSM is in PLAYING
// ---------------------------------------------------------------------------
module tone_generator
    import tone_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic                  sys_clk,
    input  logic                  async_rst,
    input  logic [7:0]            key,
    output logic                  audio_out,
    output logic                  note_valid,
    output logic [NOTE_IDX_W-1:0] note_index,
    output logic                  playing
);

    localparam longint CNT_MAX = longint'((1 << CNT_W) - 1);

    logic                  dec_valid;
    logic [NOTE_IDX_W-1:0] dec_index;

    logic                  note_valid_q, note_valid_d;
    logic [NOTE_IDX_W-1:0] note_index_q, note_index_d;
    tone_state_e           state_q, state_d;
    logic                  audio_q, audio_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [CNT_W-1:0]      base_half [2**NOTE_IDX_W];
    logic [CNT_W-1:0]      base_sel;
    logic [CNT_W-1:0]      eff_half;
    logic [CNT_W-1:0]      reload;

    note_decoder u_note_decoder (
        .key   (key),
        .valid (dec_valid),
        .index (dec_index)
    );

    // Constant half-period table; unused index slots read as zero. The range
    // checks refuse any clock rate whose effective half-period will not fit
    // the counter, or collapses to zero cycles.
    for (genvar i = 0; i < 2**NOTE_IDX_W; i++) begin : g_half
        if (i < NUM_NOTES) begin : g_note
            localparam longint BASE =
                half_period(longint'(CLK_FREQ_HZ), longint'(NOTE_FREQ_MHZ[i]));
`ifdef TONE_GENERATOR_OCTAVE_KEYS_EN
            localparam longint MAX_EFF = BASE << 1;
            localparam longint MIN_EFF = BASE >> 1;
`else
            localparam longint MAX_EFF = BASE;
            localparam longint MIN_EFF = BASE;
`endif
            if (MAX_EFF > CNT_MAX) begin : g_too_long
                $error("tone_generator: half-period exceeds the 20-bit counter");
            end
            if (MIN_EFF < 64'sd1) begin : g_too_short
                $error("tone_generator: half-period rounds to zero cycles");
            end
            assign base_half[i] = CNT_W'(BASE);
        end else begin : g_unused
            assign base_half[i] = '0;
        end
    end

    assign base_sel = base_half[note_index_q];

`ifdef TONE_GENERATOR_OCTAVE_KEYS_EN
    logic [7:0] key_q, key_prev_q;
    logic [1:0] octave_q, octave_d;

    // An octave key acts once per new appearance on the registered code,
    // so holding it down only moves one octave.
    always_comb begin
        octave_d = octave_q;
        if (key_q == SC_OCT_UP && key_prev_q != SC_OCT_UP && octave_q != 2'd2) begin
            octave_d = octave_q + 2'd1;
        end else if (key_q == SC_OCT_DOWN && key_prev_q != SC_OCT_DOWN && octave_q != 2'd0) begin
            octave_d = octave_q - 2'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            key_q      <= '0;
            key_prev_q <= '0;
            octave_q   <= 2'd1;
        end else begin
            key_q      <= key;
            key_prev_q <= key_q;
            octave_q   <= octave_d;
        end
    end

    // Octave 3 doubles the half-period, octave 5 halves it
    always_comb begin
        case (octave_q)
            2'd0:    eff_half = base_sel << 1;
            2'd2:    eff_half = base_sel >> 1;
            default: eff_half = base_sel;
        endcase
    end
`else
    always_comb begin
        eff_half = base_sel;
    end
`endif

    assign reload = eff_half - CNT_W'(1);

    // Registered copy of the decoder output
    always_comb begin
        note_valid_d = dec_valid;
        note_index_d = dec_valid ? dec_index : '0;
    end

    // Start/stop and period counter. Stopping wins over a reload in the
    // same cycle, and a note change only takes effect at the next reload.
    always_comb begin
        state_d = state_q;
        audio_d = audio_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                audio_d = 1'b0;
                cnt_d   = '0;
                if (note_valid_q) begin
                    state_d = PLAYING;
                    audio_d = 1'b1;
                    cnt_d   = reload;
                end
            end
            PLAYING: begin
                if (!note_valid_q) begin
                    state_d = IDLE;
                    audio_d = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    audio_d = ~audio_q;
                    cnt_d   = reload;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                audio_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            note_valid_q <= 1'b0;
            note_index_q <= '0;
            state_q      <= IDLE;
            audio_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            note_valid_q <= note_valid_d;
            note_index_q <= note_index_d;
            state_q      <= state_d;
            audio_q      <= audio_d;
            cnt_q        <= cnt_d;
        end
    end

    assign audio_out  = audio_q;
    assign note_valid = note_valid_q;
    assign note_index = note_index_q;
    assign playing    = (state_q == PLAYING);

endmodule

// File: tb/tb_tone_generator.sv
// ---------------------------------------------------------------------------
// tb_tone_generator
// Directed bench for tone_generator. The DUT runs at CLK_FREQ_HZ = 1 MHz so
// that whole waveforms fit in a short run; half-periods at that rate are
// floor(1e9 / (2 * f_mHz)):
//   C4 261626 -> 1911   D4 293665 -> 1702   A4 440000 -> 1136
//   C5 523251 -> 955    A4 in octave 5 -> 568, in octave 3 -> 2272
// Expected half-period segments are queued by the stimulus; the monitor
// measures every completed segment while playing and checks it against the
// front of the queue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tone_generator;

    localparam int TB_CLK_HZ = 1_000_000;
    localparam int H_C4 = 1911;
    localparam int H_D4 = 1702;
    localparam int H_A4 = 1136;
    localparam int H_C5 = 955;
`ifdef TONE_GENERATOR_OCTAVE_KEYS_EN
    localparam int H_A5 = 568;
    localparam int H_A3 = 2272;
`endif

    logic       sys_clk = 1'b0;
    logic       async_rst;
    logic [7:0] key;
    logic       audio_out;
    logic       note_valid;
    logic [3:0] note_index;
    logic       playing;

    int total_checks = 0;
    int bad_checks   = 0;

    typedef struct packed {
        logic        level;
        logic [31:0] len;
    } seg_t;

    seg_t sb_q[$];

    // Decoder vectors: code, expected valid, expected index
    logic [7:0] tbl_code [18] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                  8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B,
                                  8'h42, 8'h5A, 8'h1A, 8'h22, 8'h00, 8'hF0};
    logic       tbl_valid [18] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] tbl_index [18] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                   4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11,
                                   4'd12, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

    tone_generator #(
        .CLK_FREQ_HZ (TB_CLK_HZ)
    ) dut (
        .sys_clk    (sys_clk),
        .async_rst  (async_rst),
        .key        (key),
        .audio_out  (audio_out),
        .note_valid (note_valid),
        .note_index (note_index),
        .playing    (playing)
    );

    // 10 ns clock; posedges at 5, 15, ... and everything is sampled on negedges
    always #5 sys_clk = ~sys_clk;

    // Hard stop in case something never lets the main sequence finish
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout want sequence complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] code);
        @(negedge sys_clk);
        key = code;
    endtask

    task automatic pushSeg(input logic level, input int len);
        seg_t s;
        s.level = level;
        s.len   = len;
        sb_q.push_back(s);
    endtask

    // Waits until the monitor has consumed every queued segment
    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total_checks++;
            bad_checks++;
            $display("[TB] FAIL %s_drain: got %0d segments left want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Waits until the tone has started (audio_out high)
    task automatic waitRise(input string name, input int budget);
        int n = 0;
        while (audio_out !== 1'b1 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (audio_out !== 1'b1) begin
            total_checks++;
            bad_checks++;
            $display("[TB] FAIL %s_start: got audio %0d want 1", name, audio_out);
        end
    endtask

    // Releases the key and checks the one-cycle note_valid fall followed by
    // the return to IDLE with a silent output and a cleared counter
    task automatic stopAndCheck(input string name);
        applyStimulus(8'h00);
        @(negedge sys_clk);
        checkOutput({name, "_valid_fall"}, 32'(note_valid), 32'd0);
        checkOutput({name, "_still_playing"}, 32'(playing), 32'd1);
        @(negedge sys_clk);
        checkOutput({name, "_playing_off"}, 32'(playing), 32'd0);
        checkOutput({name, "_audio_off"}, 32'(audio_out), 32'd0);
        checkOutput({name, "_cnt_zero"}, 32'(dut.cnt_q), 32'd0);
        checkOutput({name, "_index_zero"}, 32'(note_index), 32'd0);
    endtask

    // Monitor: measures each level run of audio_out in cycles. A run is
    // checked only when it both started and ended with the FSM playing, so
    // tone start, tone stop and reset edges are not treated as toggles.
    logic mon_last  = 1'b0;
    bit   mon_valid = 1'b0;
    int   mon_cyc   = 0;
    int   mon_start = 0;

    initial begin
        seg_t exp_seg;
        forever begin
            @(negedge sys_clk);
            mon_cyc++;
            if (audio_out !== mon_last) begin
                if (mon_valid && playing) begin
                    total_checks++;
                    if (sb_q.size() == 0) begin
                        bad_checks++;
                        $display("[TB] FAIL segment_unexpected: got level %0d len %0d want none",
                                 mon_last, mon_cyc - mon_start);
                    end else begin
                        exp_seg = sb_q.pop_front();
                        if (exp_seg.level !== mon_last || exp_seg.len != 32'(mon_cyc - mon_start)) begin
                            bad_checks++;
                            $display("[TB] FAIL segment: got level %0d len %0d want level %0d len %0d",
                                     mon_last, mon_cyc - mon_start, exp_seg.level, exp_seg.len);
                        end
                    end
                end
                mon_valid = playing;
                mon_start = mon_cyc;
                mon_last  = audio_out;
            end else if (!playing) begin
                mon_valid = 1'b0;
            end
        end
    end

    // Main directed sequence
    initial begin
        int high_seen;
        async_rst = 1'b1;
        key       = 8'h00;
        #7;
        checkOutput("rst_audio", 32'(audio_out), 32'd0);
        checkOutput("rst_valid", 32'(note_valid), 32'd0);
        checkOutput("rst_index", 32'(note_index), 32'd0);
        checkOutput("rst_playing", 32'(playing), 32'd0);
        repeat (2) @(negedge sys_clk);
        async_rst = 1'b0;

        // Mapping table, one code per cycle, result one cycle later
        applyStimulus(tbl_code[0]);
        #1;
        checkOutput("map_latency_pre_edge", 32'(note_valid), 32'd0);
        @(negedge sys_clk);
        checkOutput("map_1C_valid", 32'(note_valid), 32'(tbl_valid[0]));
        checkOutput("map_1C_index", 32'(note_index), 32'(tbl_index[0]));
        for (int i = 1; i < 18; i++) begin
            applyStimulus(tbl_code[i]);
            @(negedge sys_clk);
            checkOutput($sformatf("map_%02h_valid", tbl_code[i]), 32'(note_valid), 32'(tbl_valid[i]));
            checkOutput($sformatf("map_%02h_index", tbl_code[i]), 32'(note_index), 32'(tbl_index[i]));
        end
        @(negedge sys_clk);
        checkOutput("map_end_playing", 32'(playing), 32'd0);

        // A4 held: two full periods of 1136 high / 1136 low
        applyStimulus(8'h33);
        @(negedge sys_clk);
        checkOutput("a4_index", 32'(note_index), 32'd9);
        pushSeg(1'b1, H_A4);
        pushSeg(1'b0, H_A4);
        pushSeg(1'b1, H_A4);
        pushSeg(1'b0, H_A4);
        waitDrain("a4", 6000);
        stopAndCheck("a4_stop");

        // C4 released in the middle of a high half-period
        applyStimulus(8'h1C);
        waitRise("c4_mid", 10);
        repeat (700) @(negedge sys_clk);
        stopAndCheck("c4_mid_stop");

        // C4 -> D4 while playing: the running half-period keeps its length
        applyStimulus(8'h1C);
        waitRise("c4d4", 10);
        pushSeg(1'b1, H_C4);
        pushSeg(1'b0, H_D4);
        pushSeg(1'b1, H_D4);
        repeat (600) @(negedge sys_clk);
        applyStimulus(8'h1B);
        waitDrain("c4d4", 7000);
        stopAndCheck("c4d4_stop");

        // Release timed so the stop lands on the low->high reload cycle
        applyStimulus(8'h1C);
        waitRise("coinc", 10);
        pushSeg(1'b1, H_C4);
        repeat (2 * H_C4 - 2) @(negedge sys_clk);
        key = 8'h00;
        @(negedge sys_clk);
        checkOutput("coinc_pre_playing", 32'(playing), 32'd1);
        checkOutput("coinc_pre_audio", 32'(audio_out), 32'd0);
        @(negedge sys_clk);
        checkOutput("coinc_playing", 32'(playing), 32'd0);
        checkOutput("coinc_audio", 32'(audio_out), 32'd0);
        waitDrain("coinc", 10);

        // Unmapped key stays silent
        applyStimulus(8'h5A);
        high_seen = 0;
        repeat (3000) begin
            @(negedge sys_clk);
            if (audio_out !== 1'b0) high_seen++;
        end
        checkOutput("unmapped_valid", 32'(note_valid), 32'd0);
        checkOutput("unmapped_index", 32'(note_index), 32'd0);
        checkOutput("unmapped_audio_high_cycles", 32'(high_seen), 32'd0);

        // Asynchronous reset between edges while the tone is high
        applyStimulus(8'h33);
        waitRise("rst_mid", 10);
        repeat (300) @(negedge sys_clk);
        #2;
        async_rst = 1'b1;
        key       = 8'h42;
        #1;
        checkOutput("rst_mid_audio", 32'(audio_out), 32'd0);
        checkOutput("rst_mid_playing", 32'(playing), 32'd0);
        checkOutput("rst_mid_valid", 32'(note_valid), 32'd0);
        checkOutput("rst_mid_index", 32'(note_index), 32'd0);
        checkOutput("rst_mid_cnt", 32'(dut.cnt_q), 32'd0);
        repeat (2) @(negedge sys_clk);
        async_rst = 1'b0;
        pushSeg(1'b1, H_C5);
        pushSeg(1'b0, H_C5);
        waitRise("rst_c5", 10);
        waitDrain("rst_c5", 3000);
        stopAndCheck("rst_c5_stop");

`ifdef TONE_GENERATOR_OCTAVE_KEYS_EN
        // Up three times saturates at octave 5
        repeat (3) begin
            applyStimulus(8'h22);
            applyStimulus(8'h00);
        end
        applyStimulus(8'h33);
        pushSeg(1'b1, H_A5);
        pushSeg(1'b0, H_A5);
        waitDrain("oct5", 2000);
        stopAndCheck("oct5_stop");

        // Down three times from octave 5 saturates at octave 3
        repeat (3) begin
            applyStimulus(8'h1A);
            applyStimulus(8'h00);
        end
        applyStimulus(8'h33);
        pushSeg(1'b1, H_A3);
        pushSeg(1'b0, H_A3);
        waitDrain("oct3", 6000);
        stopAndCheck("oct3_stop");
`else
        // Octave keys have no effect in this build
        repeat (2) begin
            applyStimulus(8'h22);
            applyStimulus(8'h00);
        end
        applyStimulus(8'h33);
        pushSeg(1'b1, H_A4);
        pushSeg(1'b0, H_A4);
        waitDrain("oct_ignored", 3000);
        stopAndCheck("oct_ignored_stop");
`endif

        repeat (5) @(negedge sys_clk);
        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
